mult_vl_arbiter: RTL and testbench

- Shares one variable-latency 32x32 signed multiplier among NUM_REQ requesters.
- Each requester hands over an operand pair with a valid/ready handshake.
- The block grants requesters round-robin, sequences the multiplier's start/valid protocol, and enforces a per-operation watchdog.
- Results return on one response channel, tagged with the requester ID. The block sits between the request masters and the multiplier instance.

---
 rtl/mult_vl_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mult_vl_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_vl_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_vl_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_vl_pkg;

    localparam int unsigned MULT_W      = 32;
    localparam int unsigned PROD_W      = 64;
    localparam int unsigned DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Response payload held stable while waiting for the consumer.
    typedef struct packed {
        logic              err;
        logic [PROD_W-1:0] prodt;
    } rsp_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    logic [ID_W-1:0] cand;
    logic            found;

    // Scan from rr_ptr upward with wrap-around, keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (enable && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_vl_arbiter.sv
// Shares one variable-latency multiplier among NUM_REQ requesters with a watchdog.
module mult_vl_arbiter
    import mult_vl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MULT_W-1:0] req_mlier,
    input  logic [NUM_REQ*MULT_W-1:0] req_mcand,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_prodt,
    output logic                      rsp_err,
    output logic                      m_start,
    output logic [MULT_W-1:0]         m_mlier,
    output logic [MULT_W-1:0]         m_mcand,
    input  logic [PROD_W-1:0]         m_prodt,
    input  logic                      m_valid,
    output logic                      busy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     arb_idx;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_any;
    logic                accept;
    logic                done_ok;
    logic                done_to;
    logic [WD_W-1:0]     wdog;
    logic [MULT_W-1:0]   mlier_a [NUM_REQ];
    logic [MULT_W-1:0]   mcand_a [NUM_REQ];
    rsp_data_t           rsp_q;

    // Unpack the flat operand buses into per-requester words.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign mlier_a[g] = req_mlier[MULT_W*g +: MULT_W];
        assign mcand_a[g] = req_mcand[MULT_W*g +: MULT_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .enable  (state == IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Grant is only offered in IDLE; the handshake completes in that cycle.
    assign arb_any   = |arb_gnt;
    assign req_ready = arb_gnt;
    assign rsp_prodt = rsp_q.prodt;
    assign rsp_err   = rsp_q.err;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a multiplier result beats a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (m_valid) begin
                    done_ok   = 1'b1;
                    state_nxt = RESP;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    done_to   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, pointer, watchdog and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            wdog      <= '0;
            m_start   <= 1'b0;
            m_mlier   <= '0;
            m_mcand   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            busy      <= 1'b0;
        end else begin
            m_start   <= (state_nxt == RUN);
            rsp_valid <= (state_nxt == RESP);
            busy      <= (state_nxt != IDLE);
            if (accept) begin
                m_mlier <= mlier_a[arb_idx];
                m_mcand <= mcand_a[arb_idx];
                rsp_id  <= arb_idx;
                wdog    <= '0;
                rr_ptr  <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
            end else if (state == RUN) begin
                wdog <= wdog + WD_W'(1);
            end
            if (done_ok) begin
                rsp_q.prodt <= m_prodt;
                rsp_q.err   <= 1'b0;
            end else if (done_to) begin
                rsp_q.prodt <= '0;
                rsp_q.err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_vl_arbiter.sv
// Randomized scoreboard bench for mult_vl_arbiter with a behavioural multiplier.
module tb_mult_vl_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 40;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_mlier;
    logic [NR*32-1:0]  req_mcand;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [63:0]       rsp_prodt;
    logic              rsp_err;
    logic              m_start;
    logic [31:0]       m_mlier;
    logic [31:0]       m_mcand;
    logic [63:0]       m_prodt;
    logic              m_valid;
    logic              busy;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [31:0]   a;
        logic [31:0]   b;
    } op_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [63:0]   prod;
        logic          err;
    } exp_t;

    op_t         pend_q[$];
    exp_t        exp_q[$];
    int          lat_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          phase     = 0;   // 0 idle, 1 multiplying, 2 response pending
    int          run_cnt   = 0;
    int          run_len   = 0;
    int          resp_cnt  = 0;
    int          ptr       = 0;
    int          lat_force = -1;
    int          rdy_mode  = 0;
    bit          drop_mode = 1'b0;
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic [31:0] a_arr [NR];
    logic [31:0] b_arr [NR];

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_mlier[32*g +: 32] = a_arr[g];
        assign req_mcand[32*g +: 32] = b_arr[g];
    end

    mult_vl_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (IW),
        .TIMEOUT (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mlier (req_mlier),
        .req_mcand (req_mcand),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prodt (rsp_prodt),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_mlier   (m_mlier),
        .m_mcand   (m_mcand),
        .m_prodt   (m_prodt),
        .m_valid   (m_valid),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = 64'($signed(a));
        y = 64'($signed(b));
        return x * y;
    endfunction

    // Round-robin rule: first valid requester at or after p, wrapping.
    function automatic int winner(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < int'(NR); k++) begin
            int i;
            i = (p + k) % int'(NR);
            if (((v >> i) & NR'(1)) != '0) return i;
        end
        return -1;
    endfunction

    function automatic int head(input int id);
        for (int k = 0; k < pend_q.size(); k++) begin
            if (pend_q[k].id == IW'(id)) return k;
        end
        return -1;
    endfunction

    // 0 means the multiplier never answers.
    function automatic int pick_lat();
        int r;
        if (lat_force >= 0) return lat_force;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 0;
        if (r == 1) return int'(TO);
        if (r == 2) return int'(TO) + 1;
        return int'($urandom_range(1, 10));
    endfunction

    task automatic add_op(input int id, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.id = IW'(id);
        o.a  = a;
        o.b  = b;
        pend_q.push_back(o);
    endtask

    task automatic drive();
        logic [NR-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NR); i++) begin
            int k;
            k = head(i);
            if (k >= 0) begin
                a_arr[IW'(i)] = pend_q[k].a;
                b_arr[IW'(i)] = pend_q[k].b;
                if (!drop_mode || $urandom_range(0, 3) != 0) v = v | (NR'(1) << i);
            end else begin
                a_arr[IW'(i)] = $urandom;
                b_arr[IW'(i)] = $urandom;
            end
        end
        req_valid = v;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = (phase == 2) && (resp_cnt >= 10);
        endcase
    endtask

    // Reference model: phase-level view of one operation and grant prediction.
    task automatic model_step();
        int   w;
        int   k;
        int   lat;
        exp_t e;
        op_t  o;
        chk("busy", 64'(busy), 64'(phase != 0));
        chk("m_start", 64'(m_start), 64'(phase == 1));
        chk("rsp_valid", 64'(rsp_valid), 64'(phase == 2));
        case (phase)
            0: begin
                w = winner(req_valid, ptr);
                chk("req_ready", 64'(req_ready), (w >= 0) ? 64'(NR'(1) << w) : 64'(0));
                if (w >= 0) begin
                    k = head(w);
                    o = pend_q[k];
                    pend_q.delete(k);
                    lat = pick_lat();
                    lat_q.push_back(lat);
                    e.id   = IW'(w);
                    e.err  = (lat == 0) || (lat > int'(TO));
                    e.prod = e.err ? 64'(0) : smul(o.a, o.b);
                    exp_q.push_back(e);
                    run_len = e.err ? int'(TO) : lat;
                    cur_a   = o.a;
                    cur_b   = o.b;
                    ptr     = (w + 1) % int'(NR);
                    run_cnt = 0;
                    phase   = 1;
                end
            end
            1: begin
                chk("req_ready_run", 64'(req_ready), 64'(0));
                chk("m_mlier", 64'(m_mlier), 64'(cur_a));
                chk("m_mcand", 64'(m_mcand), 64'(cur_b));
                run_cnt++;
                if (run_cnt == run_len) begin
                    phase    = 2;
                    resp_cnt = 0;
                end
            end
            default: begin
                chk("req_ready_resp", 64'(req_ready), 64'(0));
                if (rsp_ready) phase = 0;
                resp_cnt++;
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge clock);
        drive();
        #2;
        model_step();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || phase != 0 || exp_q.size() != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(n >= max_cyc), 64'(0));
    endtask

    // Behavioural multiplier: answers after the latency chosen for this operation.
    initial begin
        int mcyc;
        int mlat;
        mcyc    = 0;
        mlat    = 0;
        m_valid = 1'b0;
        m_prodt = '0;
        forever begin
            @(negedge clock);
            if (m_start) begin
                if (mcyc == 0) mlat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                mcyc++;
                m_valid = (mlat != 0) && (mcyc == mlat);
                m_prodt = m_valid ? smul(m_mlier, m_mcand) : {$urandom, $urandom};
            end else begin
                mcyc    = 0;
                m_valid = ($urandom_range(0, 7) == 0);
                m_prodt = {$urandom, $urandom};
            end
        end
    end

    // Response monitor: every presented response must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_prodt", rsp_prodt, e.prod);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            a_arr[IW'(i)] = '0;
            b_arr[IW'(i)] = '0;
        end
        repeat (2) @(negedge clock);
        #2;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_start", 64'(m_start), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_prodt", rsp_prodt, 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_m_mlier", 64'(m_mlier), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        @(negedge clock);
        reset = 1'b0;

        // Single products, positive and negative.
        lat_force = 3;
        add_op(0, 32'd3, 32'd5);
        drain(200);
        lat_force = 5;
        add_op(2, 32'hFFFF_FFFE, 32'd7);
        drain(200);

        // All requesters at once, two rounds.
        lat_force = -1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(NR); i++) add_op(i, 32'(i + 1), 32'(i + 1));
            drain(800);
        end

        // Consumer stalls for 10 cycles on each response.
        rdy_mode = 2;
        for (int i = 0; i < int'(NR); i++) add_op(i, $urandom, $urandom);
        drain(800);
        rdy_mode = 0;

        // Watchdog: never answers, answers on the last allowed cycle, one too late.
        lat_force = 0;
        add_op(3, 32'd12, 32'd13);
        drain(200);
        lat_force = int'(TO);
        add_op(2, 32'd100, 32'hFFFF_FFF6);
        drain(200);
        lat_force = int'(TO) + 1;
        add_op(1, 32'd7, 32'd8);
        drain(200);
        lat_force = 2;
        add_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drain(200);

        // Reset in the 5th RUN cycle, then check pointer restart.
        lat_force = 20;
        add_op(1, 32'd6, 32'd7);
        n = 0;
        while (!(phase == 1 && run_cnt == 4) && n < 50) begin
            cycle();
            n++;
        end
        chk("reset_setup_timeout", 64'(n >= 50), 64'(0));
        @(negedge clock);
        req_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_m_start", 64'(m_start), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        phase   = 0;
        ptr     = 0;
        run_cnt = 0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clock);
        reset     = 1'b0;
        lat_force = 4;
        add_op(3, 32'd9, 32'd9);
        add_op(1, 32'd11, 32'hFFFF_FFFD);
        drain(200);

        // Randomized traffic with dropouts, stalls and random latencies.
        lat_force = -1;
        drop_mode = 1'b1;
        rdy_mode  = 1;
        for (int k = 0; k < 60; k++) add_op(int'($urandom_range(0, NR - 1)), $urandom, $urandom);
        drain(20000);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
